// File: rtl/cafe_state_monitor.sv
// Passive protocol checker for the coffee-machine controller state bus.
// Optional brew-cycle length measurement is built when CAFE_MON_CYCLE_LEN_EN is defined.
module cafe_state_monitor #(
  parameter int CUP_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       state_in,
  input  logic             start_in,
  input  logic             clear,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic             err_sticky,
  output logic [CUP_W-1:0] cups_done,
  output logic [LEN_W-1:0] cycle_len,
  output logic             len_valid,
  output logic             water_seen,
  output logic             synced
);

  typedef enum logic [0:0] {
    ST_SYNC  = 1'b0,
    ST_CHECK = 1'b1
  } mon_state_t;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_ILLEGAL = 3'd1;
  localparam logic [2:0] E_STALL   = 3'd2;
  localparam logic [2:0] E_START   = 3'd3;
  localparam logic [2:0] E_WATER   = 3'd4;
  localparam logic [2:0] E_BAD     = 3'd5;

  localparam logic [3:0] S_IDLE     = 4'd1;
  localparam logic [3:0] S_LIGAR    = 4'd2;
  localparam logic [3:0] S_VERIFICAR = 4'd3;
  localparam logic [3:0] S_ENCHER   = 4'd4;
  localparam logic [3:0] S_MOER     = 4'd5;
  localparam logic [3:0] S_EXTRACAO = 4'd9;

  localparam logic [CUP_W-1:0] CUP_MAX = {CUP_W{1'b1}};
  localparam logic [CUP_W-1:0] CUP_ONE = {{(CUP_W-1){1'b0}}, 1'b1};

  // Classify one sampled transition; codes are checked in priority order.
  function automatic logic [2:0] classify_step(
    input logic [3:0] prev,
    input logic [3:0] cur,
    input logic       start_d,
    input logic       water
  );
    logic [2:0] code;
    code = E_NONE;
    if ((cur == 4'd0) || (cur > 4'd9)) begin
      code = E_ILLEGAL;
    end else if ((cur == prev) && (cur != S_IDLE)) begin
      code = E_STALL;
    end else begin
      case (prev)
        4'd1: begin
          if (cur == S_IDLE)       code = start_d ? E_START : E_NONE;
          else if (cur == S_LIGAR) code = start_d ? E_NONE : E_START;
          else                     code = E_BAD;
        end
        4'd2: code = (cur == 4'd3) ? E_NONE : E_BAD;
        4'd3: begin
          if (cur == S_ENCHER)     code = water ? E_WATER : E_NONE;
          else if (cur == S_MOER)  code = water ? E_NONE : E_WATER;
          else                     code = E_BAD;
        end
        4'd4: code = (cur == 4'd3) ? E_NONE : E_BAD;
        4'd5: code = (cur == 4'd6) ? E_NONE : E_BAD;
        4'd6: code = (cur == 4'd7) ? E_NONE : E_BAD;
        4'd7: code = (cur == 4'd8) ? E_NONE : E_BAD;
        4'd8: code = (cur == 4'd9) ? E_NONE : E_BAD;
        4'd9: code = (cur == 4'd1) ? E_NONE : E_BAD;
        default: code = E_BAD;
      endcase
    end
    return code;
  endfunction

  mon_state_t       state_r, state_nxt_s;
  logic [3:0]       prev_state_r;
  logic             start_d_r;
  logic [2:0]       step_code_s;
  logic             in_check_s;
  logic             violation_s;
  logic             cup_event_s;

  logic             err_pulse_r, err_pulse_nxt_s;
  logic [2:0]       err_code_r, err_code_nxt_s;
  logic             err_sticky_r, err_sticky_nxt_s;
  logic [CUP_W-1:0] cups_done_r, cups_done_nxt_s;
  logic             water_seen_r, water_seen_nxt_s;
  logic             synced_r, synced_nxt_s;

  // Transition classification and the events derived from it.
  always_comb begin
    step_code_s = classify_step(prev_state_r, state_in, start_d_r, water_seen_r);
    in_check_s  = (state_r == ST_CHECK);
    violation_s = in_check_s && (step_code_s != E_NONE);
    cup_event_s = in_check_s && !violation_s &&
                  (prev_state_r == S_EXTRACAO) && (state_in == S_IDLE);
  end

  // Monitor FSM state register plus the one-sample history of the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_SYNC;
      prev_state_r <= S_IDLE;
      start_d_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      prev_state_r <= state_in;
      start_d_r    <= start_in;
    end
  end

  // Next-state logic: a violation drops back to SYNC unless IDLE is already on the bus.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SYNC: begin
        if (state_in == S_IDLE) state_nxt_s = ST_CHECK;
        else                    state_nxt_s = ST_SYNC;
      end
      ST_CHECK: begin
        if (violation_s && (state_in != S_IDLE)) state_nxt_s = ST_SYNC;
        else                                     state_nxt_s = ST_CHECK;
      end
      default: state_nxt_s = ST_SYNC;
    endcase
  end

  // Output next values; a violation beats clear on err_sticky, clear beats a cup increment.
  always_comb begin
    err_pulse_nxt_s = violation_s;
    if (violation_s) err_code_nxt_s = step_code_s;
    else             err_code_nxt_s = err_code_r;
    if (violation_s) err_sticky_nxt_s = 1'b1;
    else if (clear)  err_sticky_nxt_s = 1'b0;
    else             err_sticky_nxt_s = err_sticky_r;
    if (clear)                                    cups_done_nxt_s = {CUP_W{1'b0}};
    else if (cup_event_s && (cups_done_r != CUP_MAX)) cups_done_nxt_s = cups_done_r + CUP_ONE;
    else                                          cups_done_nxt_s = cups_done_r;
    water_seen_nxt_s = water_seen_r | (state_in == S_ENCHER);
    synced_nxt_s     = (state_nxt_s == ST_CHECK);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_r  <= 1'b0;
      err_code_r   <= 3'd0;
      err_sticky_r <= 1'b0;
      cups_done_r  <= {CUP_W{1'b0}};
      water_seen_r <= 1'b0;
      synced_r     <= 1'b0;
    end else begin
      err_pulse_r  <= err_pulse_nxt_s;
      err_code_r   <= err_code_nxt_s;
      err_sticky_r <= err_sticky_nxt_s;
      cups_done_r  <= cups_done_nxt_s;
      water_seen_r <= water_seen_nxt_s;
      synced_r     <= synced_nxt_s;
    end
  end

  assign err_pulse  = err_pulse_r;
  assign err_code   = err_code_r;
  assign err_sticky = err_sticky_r;
  assign cups_done  = cups_done_r;
  assign water_seen = water_seen_r;
  assign synced     = synced_r;

`ifdef CAFE_MON_CYCLE_LEN_EN
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic             run_start_s;
  logic [LEN_W-1:0] cycle_cnt_r;
  logic [LEN_W-1:0] cycle_len_r;
  logic             len_valid_r;

  always_comb begin
    run_start_s = in_check_s && !violation_s &&
                  (prev_state_r == S_IDLE) && (state_in == S_LIGAR);
  end

  // Running brew length: restarted by a legal start, discarded by any violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= {LEN_W{1'b0}};
      cycle_len_r <= {LEN_W{1'b0}};
      len_valid_r <= 1'b0;
    end else begin
      if (violation_s) begin
        cycle_cnt_r <= {LEN_W{1'b0}};
      end else if (run_start_s) begin
        cycle_cnt_r <= LEN_ONE;
      end else if (in_check_s && (state_in != S_IDLE) && (cycle_cnt_r != LEN_MAX)) begin
        cycle_cnt_r <= cycle_cnt_r + LEN_ONE;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (cup_event_s) cycle_len_r <= cycle_cnt_r;
      else             cycle_len_r <= cycle_len_r;
      len_valid_r <= cup_event_s;
    end
  end

  assign cycle_len = cycle_len_r;
  assign len_valid = len_valid_r;
`else
  assign cycle_len = {LEN_W{1'b0}};
  assign len_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cafe_state_monitor.sv
// Scoreboard bench for cafe_state_monitor; expectations adapt to CAFE_MON_CYCLE_LEN_EN.
module tb_cafe_state_monitor;

`ifdef CAFE_MON_CYCLE_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  state_in = 4'd1;
  logic        start_in = 1'b0;
  logic        clear = 1'b0;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic        err_sticky;
  logic [15:0] cups_done;
  logic [7:0]  cycle_len;
  logic        len_valid;
  logic        water_seen;
  logic        synced;

  cafe_state_monitor #(.CUP_W(16), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .start_in(start_in),
    .clear(clear), .err_pulse(err_pulse), .err_code(err_code),
    .err_sticky(err_sticky), .cups_done(cups_done), .cycle_len(cycle_len),
    .len_valid(len_valid), .water_seen(water_seen), .synced(synced)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pulse;
    logic [2:0]  code;
    logic        sticky;
    logic [15:0] cups;
    logic [7:0]  len;
    logic        lval;
    logic        water;
    logic        sync;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int lv_count = 0;
  int ep_count = 0;

  // Reference model state.
  logic [3:0]  m_prev;
  logic        m_startd;
  logic        m_sync;
  logic        m_water;
  logic [2:0]  m_code;
  logic        m_sticky;
  logic [15:0] m_cups;
  logic [7:0]  m_cnt;
  logic [7:0]  m_len;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_prev = 4'd1; m_startd = 1'b0; m_sync = 1'b0; m_water = 1'b0;
    m_code = 3'd0; m_sticky = 1'b0; m_cups = 16'd0; m_cnt = 8'd0; m_len = 8'd0;
  endtask

  function automatic logic [3:0] succ(input logic [3:0] p);
    case (p)
      4'd2: return 4'd3;
      4'd4: return 4'd3;
      4'd5: return 4'd6;
      4'd6: return 4'd7;
      4'd7: return 4'd8;
      4'd8: return 4'd9;
      4'd9: return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  task automatic step(input logic [3:0] s, input logic st, input logic clr);
    exp_t e;
    int   code;
    logic lv;
    state_in = s; start_in = st; clear = clr;
    code = 0; lv = 1'b0;
    if (m_sync) begin
      if (s == 4'd0 || s > 4'd9) code = 1;
      else if (s == m_prev && s != 4'd1) code = 2;
      else if (m_prev == 4'd1 && (s == 4'd1 || s == 4'd2)) code = ((s == 4'd2) == m_startd) ? 0 : 3;
      else if (m_prev == 4'd3 && (s == 4'd4 || s == 4'd5)) code = ((s == 4'd5) == m_water) ? 0 : 4;
      else if (succ(m_prev) != s) code = 5;
    end
    if (code != 0) begin
      m_code = 3'(code); m_sticky = 1'b1; m_cnt = 8'd0; m_sync = (s == 4'd1);
    end else begin
      if (clr) m_sticky = 1'b0;
      if (m_sync) begin
        if (m_prev == 4'd9 && s == 4'd1) begin
          lv = 1'b1; m_len = m_cnt;
          if (m_cups != 16'hFFFF) m_cups = m_cups + 16'd1;
        end
        if (m_prev == 4'd1 && s == 4'd2) m_cnt = 8'd1;
        else if (s != 4'd1 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end else begin
        m_sync = (s == 4'd1);
      end
    end
    if (clr) m_cups = 16'd0;
    e.pulse = (code != 0); e.code = m_code; e.sticky = m_sticky; e.cups = m_cups;
    e.len = LEN_EN ? m_len : 8'd0; e.lval = LEN_EN ? lv : 1'b0;
    m_water = m_water | (s == 4'd4);
    e.water = m_water; e.sync = m_sync;
    m_prev = s; m_startd = st;
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    if (len_valid) lv_count++;
    if (err_pulse) ep_count++;
    check_eq("err_pulse", 32'(err_pulse), 32'(e.pulse));
    check_eq("err_code", 32'(err_code), 32'(e.code));
    check_eq("err_sticky", 32'(err_sticky), 32'(e.sticky));
    check_eq("cups_done", 32'(cups_done), 32'(e.cups));
    check_eq("cycle_len", 32'(cycle_len), 32'(e.len));
    check_eq("len_valid", 32'(len_valid), 32'(e.lval));
    check_eq("water_seen", 32'(water_seen), 32'(e.water));
    check_eq("synced", 32'(synced), 32'(e.sync));
  endtask

  task automatic play(input int q[$]);
    foreach (q[i]) step(4'(q[i]), 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pulse"}, 32'(err_pulse), 32'd0);
    check_eq({tag, "_code"}, 32'(err_code), 32'd0);
    check_eq({tag, "_sticky"}, 32'(err_sticky), 32'd0);
    check_eq({tag, "_cups"}, 32'(cups_done), 32'd0);
    check_eq({tag, "_len"}, 32'(cycle_len), 32'd0);
    check_eq({tag, "_lval"}, 32'(len_valid), 32'd0);
    check_eq({tag, "_water"}, 32'(water_seen), 32'd0);
    check_eq({tag, "_synced"}, 32'(synced), 32'd0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: idle, start pulse, first cup with water fill.
    repeat (3) step(4'd1, 1'b0, 1'b0);
    step(4'd1, 1'b1, 1'b0);
    lv_count = 0; ep_count = 0;
    play('{2, 3, 4, 3, 5, 6, 7, 8, 9, 1});
    check_eq("s1_cups", 32'(cups_done), 32'd1);
    check_eq("s1_cycle_len", 32'(cycle_len), LEN_EN ? 32'd9 : 32'd0);
    check_eq("s1_len_pulses", 32'(lv_count), LEN_EN ? 32'd1 : 32'd0);
    check_eq("s1_water", 32'(water_seen), 32'd1);
    check_eq("s1_err_pulses", 32'(ep_count), 32'd0);

    // Scenario 2: second cup skips the fill.
    step(4'd1, 1'b1, 1'b0);
    play('{2, 3, 5, 6, 7, 8, 9, 1});
    check_eq("s2_cups", 32'(cups_done), 32'd2);
    check_eq("s2_cycle_len", 32'(cycle_len), LEN_EN ? 32'd7 : 32'd0);
    check_eq("s2_sticky", 32'(err_sticky), 32'd0);

    // Water violation, then resync.
    step(4'd1, 1'b1, 1'b0);
    play('{2, 3, 4});
    check_eq("water_code", 32'(err_code), 32'd4);
    check_eq("water_synced", 32'(synced), 32'd0);
    step(4'd1, 1'b0, 1'b0);
    check_eq("water_pulse_drop", 32'(err_pulse), 32'd0);
    check_eq("resynced", 32'(synced), 32'd1);

    // Stall, then illegal code.
    step(4'd1, 1'b1, 1'b0);
    play('{2, 3, 5, 6, 6});
    check_eq("stall_code", 32'(err_code), 32'd2);
    play('{1, 12});
    check_eq("illegal_code", 32'(err_code), 32'd1);

    // Start rule, bad transition, clear interactions.
    play('{1, 2});
    check_eq("start_code", 32'(err_code), 32'd3);
    play('{1, 1, 1, 3});
    check_eq("bad_code", 32'(err_code), 32'd5);
    step(4'd1, 1'b0, 1'b0);
    step(4'd1, 1'b1, 1'b0);
    step(4'd1, 1'b0, 1'b1);
    check_eq("clear_vs_violation", 32'(err_sticky), 32'd1);
    step(4'd1, 1'b0, 1'b1);
    check_eq("clear_sticky", 32'(err_sticky), 32'd0);
    step(4'd1, 1'b1, 1'b0);
    play('{2, 3, 5, 6, 7, 8, 9});
    step(4'd1, 1'b0, 1'b1);
    check_eq("clear_vs_cup", 32'(cups_done), 32'd0);

    // Another cup, then asynchronous reset mid-cycle.
    step(4'd1, 1'b1, 1'b0);
    play('{2, 3, 5, 6, 7, 8, 9, 1, 1});
    step(4'd1, 1'b1, 1'b0);
    play('{2, 3});
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (2) step(4'd1, 1'b0, 1'b0);
    step(4'd1, 1'b1, 1'b0);
    play('{2, 3, 4, 3, 5, 6, 7, 8, 9, 1});
    check_eq("post_rst_len", 32'(cycle_len), LEN_EN ? 32'd9 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
